// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller that loads operands, starts the core, waits for halt and streams results.
// Optional CLEAR_MEM_EN macro adds a pass that zeroes the whole data memory before loading.
module prog_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] cfg_op_base,
    input  logic [2:0]        cfg_op_len,
    input  logic [ADDR_W-1:0] cfg_res_base,
    input  logic [2:0]        cfg_res_len,
    input  logic              op_valid,
    input  logic [7:0]        op_byte,
    output logic              op_ready,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              dut_start,
    input  logic              dut_halt,
    output logic              res_valid,
    output logic [7:0]        res_byte,
    output logic              res_last,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int SC_W  = $clog2(START_CYC + 1);
    localparam int CW0   = (WD_W > SC_W) ? WD_W : SC_W;
    localparam int CNT_W = (CW0 > ADDR_W + 1) ? CW0 : ADDR_W + 1;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'((1 << ADDR_W) - 1);
    localparam logic [CNT_W-1:0] STA_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT, S_READ, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] op_base_q, op_base_d;
    logic [ADDR_W-1:0] res_base_q, res_base_d;
    logic [2:0]        op_len_q, op_len_d;
    logic [2:0]        res_len_q, res_len_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] idx;
    logic              op_hs, op_end, res_hs, res_end;

    // one counter serves as clear address, operand/result index, start and watchdog timer
    assign idx     = cnt_q[ADDR_W-1:0];
    assign op_hs   = (state_q == S_LOAD) && (op_len_q != 3'd0) && op_valid;
    assign op_end  = (cnt_q + ONE) == CNT_W'(op_len_q);
    assign res_hs  = (state_q == S_READ) && (res_len_q != 3'd0) && res_ready;
    assign res_end = (cnt_q + ONE) == CNT_W'(res_len_q);

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_base_q  <= '0;
            res_base_q <= '0;
            op_len_q   <= '0;
            res_len_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_base_q  <= op_base_d;
            res_base_q <= res_base_d;
            op_len_q   <= op_len_d;
            res_len_q  <= res_len_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_base_d  = op_base_q;
        res_base_d = res_base_q;
        op_len_d   = op_len_q;
        res_len_d  = res_len_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_base_d  = cfg_op_base;
                    res_base_d = cfg_res_base;
                    op_len_d   = cfg_op_len;
                    res_len_d  = cfg_res_len;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
`ifdef CLEAR_MEM_EN
                    state_d    = S_CLEAR;
`else
                    state_d    = S_LOAD;
`endif
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (op_len_q == 3'd0) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else if (op_hs) begin
                    cnt_d = cnt_q + ONE;
                    if (op_end) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == STA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + ONE;
                // first WAIT cycle may still see the previous run's halt
                if (dut_halt && (cnt_q != '0)) begin
                    cnt_d   = '0;
                    state_d = (res_len_q == 3'd0) ? S_FIN : S_READ;
                end else if (cnt_q == WD_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_READ: begin
                if (res_len_q == 3'd0) begin
                    state_d = S_FIN;
                end else if (res_hs) begin
                    cnt_d = cnt_q + ONE;
                    if (res_end) begin
                        cnt_d   = '0;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        op_ready  = 1'b0;
        mem_sel   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        dut_start = 1'b1;
        res_valid = 1'b0;
        res_byte  = 8'h00;
        res_last  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = idx;
            end
            S_LOAD: begin
                op_ready  = op_hs;
                mem_we    = op_hs;
                mem_addr  = op_base_q + idx;
                mem_wdata = op_byte;
            end
            S_WAIT: begin
                dut_start = 1'b0;
                mem_sel   = 1'b0;
            end
            S_READ: begin
                mem_addr = res_base_q + idx;
                if (res_len_q != 3'd0) begin
                    res_valid = 1'b1;
                    res_byte  = mem_rdata;
                    res_last  = res_end;
                end
            end
            S_FIN: done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed vector table plus random runs against a byte-array memory model.
// A stub core and a 256-byte memory sit behind the sequencer's memory port.
`timescale 1ns/1ps
module tb_prog_sequencer;
    localparam int START_CYC = 2;
    localparam int TO_CYC    = 100;

    typedef struct {
        logic [7:0]      op_base;
        int              op_len;
        logic [7:0][7:0] ops;
        logic [7:0]      res_base;
        int              res_len;
        int              halt_after;
        bit              force_halt;
        bit              core_wr;
        logic [7:0]      core_addr;
        logic [7:0]      core_data;
        int              stall;
        bit              req_hold;
        int              rst_wait;
        bit              use_model;
        bit              exp_to;
        int              exp_n;
        logic [7:0][7:0] exp_res;
        int              exp_wait;
        int              max_cyc;
    } vec_t;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       req;
    logic [7:0] cfg_op_base, cfg_res_base;
    logic [2:0] cfg_op_len, cfg_res_len;
    logic       op_valid, op_ready;
    logic [7:0] op_byte;
    logic       mem_sel, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       dut_start, dut_halt;
    logic       res_valid, res_last, res_ready;
    logic [7:0] res_byte;
    logic       busy, done, timeout;

    int         checks = 0;
    int         errors = 0;

    int         halt_after = -1;
    bit         force_halt = 1'b0;
    bit         core_wr = 1'b0;
    logic [7:0] core_addr = 8'h00;
    logic [7:0] core_data = 8'h00;
    bit         tb_init = 1'b0;
    int         core_cnt = 0;
    logic       core_we;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       m_we;
    logic [7:0] m_addr, m_wdata;

    always #5 CLK = ~CLK;

    prog_sequencer #(
        .ADDR_W(8), .START_CYC(START_CYC), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .req(req),
        .cfg_op_base(cfg_op_base), .cfg_op_len(cfg_op_len),
        .cfg_res_base(cfg_res_base), .cfg_res_len(cfg_res_len),
        .op_valid(op_valid), .op_byte(op_byte), .op_ready(op_ready),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dut_start(dut_start), .dut_halt(dut_halt),
        .res_valid(res_valid), .res_byte(res_byte), .res_last(res_last),
        .res_ready(res_ready), .busy(busy), .done(done), .timeout(timeout)
    );

    // stub core: counts cycles since start fell, writes once on its first cycle
    always @(posedge CLK) core_cnt <= dut_start ? 0 : core_cnt + 1;
    assign dut_halt = force_halt || (halt_after >= 0 && core_cnt >= halt_after);
    assign core_we  = core_wr && !dut_start && (core_cnt == 0);

    assign m_we      = mem_sel ? mem_we : core_we;
    assign m_addr    = mem_sel ? mem_addr : core_addr;
    assign m_wdata   = mem_sel ? mem_wdata : core_data;
    assign mem_rdata = mem[m_addr];

    always @(posedge CLK) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (m_we) begin
            mem[m_addr] <= m_wdata;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic mem_cmp(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic model_load(input vec_t r);
`ifdef CLEAR_MEM_EN
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
`endif
        for (int i = 0; i < r.op_len; i++) ref_mem[8'(r.op_base + i)] = r.ops[i];
        if (r.core_wr) ref_mem[r.core_addr] = r.core_data;
    endtask

    function automatic vec_t dflt();
        vec_t v;
        v.op_base = 8'h00; v.op_len = 0; v.ops = '0;
        v.res_base = 8'h00; v.res_len = 0;
        v.halt_after = 5; v.force_halt = 1'b0;
        v.core_wr = 1'b0; v.core_addr = 8'h00; v.core_data = 8'h00;
        v.stall = 0; v.req_hold = 1'b0; v.rst_wait = -1; v.use_model = 1'b0;
        v.exp_to = 1'b0; v.exp_n = 0; v.exp_res = '0; v.exp_wait = -1; v.max_cyc = 0;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v = dflt();
        v.op_base = 8'($urandom);
        v.op_len  = int'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) v.ops[i] = 8'($urandom);
        v.res_base = ($urandom_range(0, 1) == 1) ? 8'(v.op_base + $urandom_range(0, 7))
                                                 : 8'($urandom);
        v.res_len    = int'($urandom_range(0, 7));
        v.halt_after = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 30));
        v.core_wr    = 1'($urandom_range(0, 1));
        v.core_addr  = 8'(v.res_base + $urandom_range(0, 3));
        v.core_data  = 8'($urandom);
        v.stall      = int'($urandom_range(0, 2));
        v.use_model  = 1'b1;
        v.exp_to     = (v.halt_after < 0);
        // halt is honoured from the second WAIT cycle onward
        v.exp_wait   = v.exp_to ? TO_CYC : ((v.halt_after < 1) ? 1 : v.halt_after) + 1;
        return v;
    endfunction

    task automatic run(input vec_t r, input string tag);
        int cyc, opi, got, nwait, nvalid, first_wait, done_cyc, stall_cnt, nbusy, ndone;
        bit holding, rst_done, to_at_done;
        logic [7:0] hold_byte, expb;
        cyc = 0; opi = 0; got = 0; nwait = 0; nvalid = 0; first_wait = -1;
        done_cyc = -1; stall_cnt = 0; nbusy = 0; ndone = 0;
        holding = 1'b0; rst_done = 1'b0; to_at_done = 1'b0; hold_byte = 8'h00;
        model_load(r);
        if (r.use_model) begin
            r.exp_n = r.exp_to ? 0 : r.res_len;
            for (int j = 0; j < 8; j++) r.exp_res[j] = ref_mem[8'(r.res_base + j)];
        end
        halt_after = r.halt_after; force_halt = r.force_halt;
        core_wr = r.core_wr; core_addr = r.core_addr; core_data = r.core_data;
        cfg_op_base = r.op_base; cfg_op_len = 3'(r.op_len);
        cfg_res_base = r.res_base; cfg_res_len = 3'(r.res_len);
        req = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        @(posedge CLK); @(negedge CLK);
        cyc = 1;
        if (!r.req_hold) req = 1'b0;
        while (cyc < 3000) begin
            cfg_op_base = 8'($urandom); cfg_res_base = 8'($urandom);
            cfg_op_len = 3'($urandom); cfg_res_len = 3'($urandom);
            op_valid = (opi < r.op_len) && ($urandom_range(0, 3) != 0);
            op_byte = op_valid ? r.ops[opi] : 8'($urandom);
            res_ready = 1'b0;
            #1;
            if (cyc == 1) chk({tag, " timeout cleared"}, timeout, 0);
            if (op_ready) opi++;
            if (!dut_start) begin
                if (first_wait < 0) first_wait = cyc;
                nwait++;
                if (nwait == r.rst_wait) begin
                    reset_n = 1'b0; req = 1'b0; op_valid = 1'b0;
                    @(posedge CLK); @(negedge CLK); #1;
                    chk({tag, " rst busy"}, busy, 0);
                    chk({tag, " rst dut_start"}, dut_start, 1);
                    chk({tag, " rst mem_sel"}, mem_sel, 1);
                    chk({tag, " rst res_valid"}, res_valid, 0);
                    chk({tag, " rst done"}, done, 0);
                    chk({tag, " rst timeout"}, timeout, 0);
                    reset_n = 1'b1;
                    rst_done = 1'b1;
                    break;
                end
            end
            if (res_valid) begin
                nvalid++;
                if (holding) chk({tag, " res held"}, res_byte, hold_byte);
                if (stall_cnt >= r.stall) begin
                    res_ready = 1'b1;
                    expb = (got < 8) ? r.exp_res[got] : 8'hxx;
                    chk({tag, " res byte"}, res_byte, expb);
                    chk({tag, " res_last"}, res_last, (got == r.exp_n - 1) ? 1 : 0);
                    got++; stall_cnt = 0; holding = 1'b0;
                end else begin
                    stall_cnt++; holding = 1'b1; hold_byte = res_byte;
                end
            end
            if (done) begin
                done_cyc = cyc; to_at_done = timeout; req = 1'b0;
            end
            @(posedge CLK); @(negedge CLK);
            cyc++;
            if (done_cyc >= 0) break;
        end
        op_valid = 1'b0; res_ready = 1'b0; req = 1'b0;
        if (rst_done) begin
            mem_cmp({tag, " mem after reset"});
            return;
        end
        chk({tag, " done seen"}, (done_cyc >= 0) ? 1 : 0, 1);
        chk({tag, " timeout at done"}, to_at_done, r.exp_to);
        chk({tag, " res count"}, got, r.exp_n);
        if (r.exp_to) begin
            chk({tag, " res_valid cycles"}, nvalid, 0);
            chk({tag, " done after WAIT entry"}, done_cyc - first_wait, TO_CYC);
        end else if (r.exp_wait >= 0) begin
            chk({tag, " wait cycles"}, nwait, r.exp_wait);
        end
        if (r.max_cyc > 0) begin
            checks++;
            if (done_cyc < 0 || done_cyc > r.max_cyc) begin
                errors++;
                $display("FAIL %s latency: actual %0d required <= %0d", tag, done_cyc, r.max_cyc);
            end
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            nbusy += int'(busy);
            ndone += int'(done);
            @(posedge CLK); @(negedge CLK);
        end
        chk({tag, " idle busy after run"}, nbusy, 0);
        chk({tag, " done pulse width"}, ndone, 0);
        chk({tag, " timeout sticky"}, timeout, r.exp_to);
        mem_cmp({tag, " mem"});
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   lat;

`ifdef CLEAR_MEM_EN
        lat = START_CYC + 4 + 256;
`else
        lat = START_CYC + 4;
`endif
        v = dflt(); v.op_base = 8'd16; v.op_len = 2; v.ops[0] = 8'h00; v.ops[1] = 8'h10;
        v.res_base = 8'd18; v.res_len = 1; v.halt_after = 20;
        v.core_wr = 1'b1; v.core_addr = 8'd18; v.core_data = 8'h04;
        v.exp_n = 1; v.exp_res[0] = 8'h04; v.exp_wait = 21;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'd4; v.op_len = 3;
        v.ops[0] = 8'hAA; v.ops[1] = 8'h55; v.ops[2] = 8'h01;
        v.res_base = 8'd4; v.res_len = 3; v.halt_after = 3; v.stall = 3;
        v.exp_n = 3; v.exp_res[0] = 8'hAA; v.exp_res[1] = 8'h55; v.exp_res[2] = 8'h01;
        v.exp_wait = 4;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'h40; v.op_len = 1; v.ops[0] = 8'h99;
        v.res_base = 8'h40; v.res_len = 2; v.halt_after = -1; v.exp_to = 1'b1;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'h30; v.op_len = 1; v.ops[0] = 8'h77;
        v.res_base = 8'h30; v.res_len = 1; v.force_halt = 1'b1;
        v.exp_n = 1; v.exp_res[0] = 8'h77; v.exp_wait = 2;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'hFF; v.op_len = 2; v.ops[0] = 8'h12; v.ops[1] = 8'h34;
        v.res_base = 8'hFF; v.res_len = 2; v.halt_after = 2;
        v.exp_n = 2; v.exp_res[0] = 8'h12; v.exp_res[1] = 8'h34; v.exp_wait = 3;
        tbl.push_back(v);

        v = dflt(); v.force_halt = 1'b1; v.exp_wait = 2; v.max_cyc = lat;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'h80; v.op_len = 3;
        v.ops[0] = 8'h01; v.ops[1] = 8'h02; v.ops[2] = 8'h03;
        v.res_base = 8'h81; v.res_len = 2; v.halt_after = 5; v.req_hold = 1'b1;
        v.exp_n = 2; v.exp_res[0] = 8'h02; v.exp_res[1] = 8'h03; v.exp_wait = 6;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'h90; v.op_len = 1; v.ops[0] = 8'h5A;
        v.res_base = 8'h90; v.res_len = 1; v.halt_after = TO_CYC - 1;
        v.exp_n = 1; v.exp_res[0] = 8'h5A; v.exp_wait = TO_CYC;
        tbl.push_back(v);

        v = dflt(); v.op_base = 8'hC0; v.op_len = 2; v.ops[0] = 8'hEE; v.ops[1] = 8'hDD;
        v.halt_after = -1; v.rst_wait = 10;
        tbl.push_back(v);

        reset_n = 1'b0; req = 1'b0; op_valid = 1'b1; op_byte = 8'h5C; res_ready = 1'b1;
        cfg_op_base = 8'h00; cfg_op_len = 3'd0; cfg_res_base = 8'h00; cfg_res_len = 3'd0;
        tb_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        tb_init = 1'b0;
        #1;
        chk("reset dut_start", dut_start, 1);
        chk("reset mem_sel", mem_sel, 1);
        chk("reset busy", busy, 0);
        chk("reset op_ready", op_ready, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset done", done, 0);
        chk("reset timeout", timeout, 0);
        @(posedge CLK); @(negedge CLK);
        reset_n = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        @(posedge CLK); @(negedge CLK);

        for (int t = 0; t < tbl.size(); t++) run(tbl[t], $sformatf("vec%0d", t));
        for (int t = 0; t < 25; t++) run(rnd_vec(), $sformatf("rnd%0d", t));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
